// File: rtl/vend_arb_pkg.sv
// Shared types for the vending-core session arbiter.
// Holds the arbiter state encoding and the item digit width.
package vend_arb_pkg;

    localparam int ITEM_CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SESSION = 2'd1,
        RELEASE = 2'd2,
        MAINT   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/vend_session_arbiter_rr_picker.sv
// Round-robin picker: first eligible index strictly after ptr, wrapping.
// Purely combinational; winner is one-hot or zero.
module rr_picker #(
    parameter int NUM_PANELS = 4,
    localparam int PW = $clog2(NUM_PANELS)
) (
    input  logic [NUM_PANELS-1:0] eligible,
    input  logic [PW-1:0]         ptr,
    output logic [NUM_PANELS-1:0] winner,
    output logic                  valid
);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_PANELS; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_PANELS);
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_session_arbiter.sv
// Grants exclusive vending-core sessions to front panels round-robin,
// detects session end, enforces a timeout and sequences maintenance reload.
module vend_session_arbiter
    import vend_arb_pkg::*;
#(
    parameter int NUM_PANELS   = 4,
    parameter int SESSION_MAX  = 32,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [NUM_PANELS-1:0]             PANEL_CARD_IN,
    input  logic [NUM_PANELS-1:0]             PANEL_KEY_PRESS,
    input  logic [ITEM_CODE_W*NUM_PANELS-1:0] PANEL_ITEM_CODE,
    input  logic                              RELOAD_REQ,
    input  logic                              CORE_VEND,
    input  logic                              CORE_INVALID_SEL,
    input  logic                              CORE_FAILED_TRAN,
    output logic [NUM_PANELS-1:0]             GRANT,
    output logic                              CORE_CARD_IN,
    output logic                              CORE_KEY_PRESS,
    output logic [ITEM_CODE_W-1:0]            CORE_ITEM_CODE,
    output logic                              CORE_RELOAD,
    output logic                              BUSY,
    output logic                              TIMEOUT
);

    localparam int PW = $clog2(NUM_PANELS);
    localparam int CW = (SESSION_MAX > 1) ? $clog2(SESSION_MAX) : 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    arb_state_e            state_q, state_d;
    logic [NUM_PANELS-1:0] grant_q, grant_d;
    logic [NUM_PANELS-1:0] served_q, served_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  pend_q, pend_d;
    logic                  vend_q, vend_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;

    logic [NUM_PANELS-1:0]  eligible;
    logic [NUM_PANELS-1:0]  pick_win;
    logic                   pick_valid;
    logic [PW-1:0]          pick_idx;
    logic [NUM_PANELS-1:0]  served_set;
    logic [ITEM_CODE_W-1:0] item_arr [NUM_PANELS];
    logic                   in_sess;
    logic                   own_card;
    logic                   vend_fall;
    logic                   timeout_hit;
    logic                   sess_end;

    assign eligible = PANEL_CARD_IN & ~served_q;

    rr_picker #(
        .NUM_PANELS(NUM_PANELS)
    ) u_pick (
        .eligible(eligible),
        .ptr     (ptr_q),
        .winner  (pick_win),
        .valid   (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_PANELS; i++) begin
            if (pick_win[i]) pick_idx = PW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PANELS; i++) begin
            item_arr[i] = PANEL_ITEM_CODE[i*ITEM_CODE_W +: ITEM_CODE_W];
        end
    end

    // ptr_q always names the owner while a session is open
    assign in_sess     = (state_q == SESSION);
    assign own_card    = PANEL_CARD_IN[ptr_q];
    assign vend_fall   = vend_q & ~CORE_VEND;
    assign timeout_hit = in_sess && (cnt_q == CW'(SESSION_MAX - 1));
    assign sess_end    = !own_card || CORE_INVALID_SEL
                      || CORE_FAILED_TRAN || vend_fall || timeout_hit;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        pend_d     = pend_q;
        vend_d     = CORE_VEND;
        cnt_d      = '0;
        gcnt_d     = '0;
        served_set = '0;
        unique case (state_q)
            IDLE: begin
                if (pend_q || RELOAD_REQ) begin
                    state_d = MAINT;
                    pend_d  = 1'b0;
                end else if (pick_valid) begin
                    state_d = SESSION;
                    grant_d = pick_win;
                    ptr_d   = pick_idx;
                end
            end
            SESSION: begin
                if (RELOAD_REQ) pend_d = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (sess_end) begin
                    state_d    = RELEASE;
                    grant_d    = '0;
                    served_set = grant_q;
                    cnt_d      = '0;
                end
            end
            RELEASE: begin
                if (RELOAD_REQ) pend_d = 1'b1;
                gcnt_d = gcnt_q + 1'b1;
                if (gcnt_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d = IDLE;
                    gcnt_d  = '0;
                end
            end
            MAINT: begin
                if (RELOAD_REQ) pend_d = 1'b1;
                state_d = RELEASE;
            end
            default: state_d = IDLE;
        endcase
        // removing a card always re-arms that panel
        served_d = (served_q | served_set) & PANEL_CARD_IN;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            served_q <= '0;
            ptr_q    <= PW'(NUM_PANELS - 1);
            pend_q   <= 1'b0;
            vend_q   <= 1'b0;
            cnt_q    <= '0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            served_q <= served_d;
            ptr_q    <= ptr_d;
            pend_q   <= pend_d;
            vend_q   <= vend_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
        end
    end

    assign GRANT          = grant_q;
    assign CORE_CARD_IN   = in_sess & own_card;
    assign CORE_KEY_PRESS = in_sess & PANEL_KEY_PRESS[ptr_q];
    assign CORE_ITEM_CODE = in_sess ? item_arr[ptr_q] : '0;
    assign CORE_RELOAD    = (state_q == MAINT);
    assign BUSY           = (state_q != IDLE);
    assign TIMEOUT        = timeout_hit;

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed bench for vend_session_arbiter (4 panels, 32-cycle limit, guard 2).
// Inputs change 1 time unit after the rising edge; outputs checked 1 unit later.
module tb_vend_session_arbiter;

    logic        CLK;
    logic        RESET;
    logic [3:0]  PANEL_CARD_IN;
    logic [3:0]  PANEL_KEY_PRESS;
    logic [15:0] PANEL_ITEM_CODE;
    logic        RELOAD_REQ;
    logic        CORE_VEND;
    logic        CORE_INVALID_SEL;
    logic        CORE_FAILED_TRAN;
    logic [3:0]  GRANT;
    logic        CORE_CARD_IN;
    logic        CORE_KEY_PRESS;
    logic [3:0]  CORE_ITEM_CODE;
    logic        CORE_RELOAD;
    logic        BUSY;
    logic        TIMEOUT;

    int n_cmp = 0;
    int n_bad = 0;

    vend_session_arbiter #(
        .NUM_PANELS  (4),
        .SESSION_MAX (32),
        .GUARD_CYCLES(2)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .PANEL_CARD_IN   (PANEL_CARD_IN),
        .PANEL_KEY_PRESS (PANEL_KEY_PRESS),
        .PANEL_ITEM_CODE (PANEL_ITEM_CODE),
        .RELOAD_REQ      (RELOAD_REQ),
        .CORE_VEND       (CORE_VEND),
        .CORE_INVALID_SEL(CORE_INVALID_SEL),
        .CORE_FAILED_TRAN(CORE_FAILED_TRAN),
        .GRANT           (GRANT),
        .CORE_CARD_IN    (CORE_CARD_IN),
        .CORE_KEY_PRESS  (CORE_KEY_PRESS),
        .CORE_ITEM_CODE  (CORE_ITEM_CODE),
        .CORE_RELOAD     (CORE_RELOAD),
        .BUSY            (BUSY),
        .TIMEOUT         (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET            = 1'b1;
        PANEL_CARD_IN    = '0;
        PANEL_KEY_PRESS  = '0;
        PANEL_ITEM_CODE  = '0;
        RELOAD_REQ       = 1'b0;
        CORE_VEND        = 1'b0;
        CORE_INVALID_SEL = 1'b0;
        CORE_FAILED_TRAN = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_grant",  32'(GRANT), 32'h0);
        chk("rst_busy",   32'(BUSY), 32'h0);
        chk("rst_card",   32'(CORE_CARD_IN), 32'h0);
        chk("rst_reload", 32'(CORE_RELOAD), 32'h0);
        chk("rst_tmo",    32'(TIMEOUT), 32'h0);

        // round-robin from reset pointer: panels 1 and 3 request
        RESET = 1'b0;
        tick();
        PANEL_CARD_IN = 4'b1010;
        #1;
        chk("rr_idle_grant", 32'(GRANT), 32'h0);
        tick();
        chk("rr_grant1", 32'(GRANT), 32'h2);
        chk("rr_card1",  32'(CORE_CARD_IN), 32'h1);
        chk("rr_busy1",  32'(BUSY), 32'h1);
        PANEL_KEY_PRESS = 4'b0011;
        PANEL_ITEM_CODE = 16'h005A;
        #1;
        chk("mux_key",  32'(CORE_KEY_PRESS), 32'h1);
        chk("mux_item", 32'(CORE_ITEM_CODE), 32'h5);
        PANEL_KEY_PRESS = 4'b0001;
        #1;
        chk("mux_key_nonowner", 32'(CORE_KEY_PRESS), 32'h0);
        PANEL_KEY_PRESS = 4'b0000;
        PANEL_CARD_IN   = 4'b1000;
        #1;
        chk("drop_card_now", 32'(CORE_CARD_IN), 32'h0);
        tick();
        chk("rel1_grant", 32'(GRANT), 32'h0);
        chk("rel1_card",  32'(CORE_CARD_IN), 32'h0);
        chk("rel1_item",  32'(CORE_ITEM_CODE), 32'h0);
        chk("rel1_busy",  32'(BUSY), 32'h1);
        tick();
        chk("rel2_card",  32'(CORE_CARD_IN), 32'h0);
        chk("rel2_busy",  32'(BUSY), 32'h1);
        tick();
        chk("idle_busy",  32'(BUSY), 32'h0);
        chk("idle_grant", 32'(GRANT), 32'h0);
        tick();
        chk("rr_grant3", 32'(GRANT), 32'h8);
        chk("rr_card3",  32'(CORE_CARD_IN), 32'h1);
        PANEL_CARD_IN = 4'b0000;
        tick();
        tick();
        tick();
        chk("idle2_busy", 32'(BUSY), 32'h0);

        // vend falling edge ends the session; served panel not regranted
        PANEL_CARD_IN = 4'b0001;
        tick();
        chk("vend_grant", 32'(GRANT), 32'h1);
        CORE_VEND = 1'b1;
        tick();
        chk("vend_high_grant", 32'(GRANT), 32'h1);
        CORE_VEND = 1'b0;
        #1;
        chk("vend_fall_grant", 32'(GRANT), 32'h1);
        tick();
        chk("vend_rel_grant", 32'(GRANT), 32'h0);
        chk("vend_rel_busy",  32'(BUSY), 32'h1);
        tick();
        tick();
        chk("served_idle", 32'(BUSY), 32'h0);
        tick();
        chk("served_no_grant", 32'(GRANT), 32'h0);
        chk("served_no_busy",  32'(BUSY), 32'h0);
        PANEL_CARD_IN = 4'b0000;
        tick();
        PANEL_CARD_IN = 4'b0001;
        #1;
        chk("reinsert_pre", 32'(GRANT), 32'h0);
        tick();
        chk("reinsert_grant", 32'(GRANT), 32'h1);

        // timeout: session cycle 0 is now
        repeat (30) tick();
        chk("tmo_c30", 32'(TIMEOUT), 32'h0);
        tick();
        chk("tmo_c31",       32'(TIMEOUT), 32'h1);
        chk("tmo_c31_grant", 32'(GRANT), 32'h1);
        tick();
        chk("tmo_after_grant", 32'(GRANT), 32'h0);
        chk("tmo_after_pulse", 32'(TIMEOUT), 32'h0);
        chk("tmo_after_busy",  32'(BUSY), 32'h1);
        PANEL_CARD_IN = 4'b0000;
        tick();
        tick();
        chk("tmo_idle", 32'(BUSY), 32'h0);

        // reload request deferred until session and guard end
        PANEL_CARD_IN = 4'b0100;
        tick();
        chk("rl_grant", 32'(GRANT), 32'h4);
        RELOAD_REQ = 1'b1;
        #1;
        chk("rl_sess_reload", 32'(CORE_RELOAD), 32'h0);
        tick();
        RELOAD_REQ = 1'b0;
        chk("rl_sess_keep", 32'(GRANT), 32'h4);
        chk("rl_sess_reload2", 32'(CORE_RELOAD), 32'h0);
        PANEL_CARD_IN = 4'b0000;
        tick();
        chk("rl_rel1", 32'(CORE_RELOAD), 32'h0);
        tick();
        chk("rl_rel2", 32'(CORE_RELOAD), 32'h0);
        tick();
        chk("rl_idle_reload", 32'(CORE_RELOAD), 32'h0);
        chk("rl_idle_busy",   32'(BUSY), 32'h0);
        PANEL_CARD_IN = 4'b1000;
        tick();
        chk("rl_maint_reload", 32'(CORE_RELOAD), 32'h1);
        chk("rl_maint_grant",  32'(GRANT), 32'h0);
        chk("rl_maint_busy",   32'(BUSY), 32'h1);
        tick();
        chk("rl_guard_reload", 32'(CORE_RELOAD), 32'h0);
        chk("rl_guard_grant",  32'(GRANT), 32'h0);
        tick();
        tick();
        chk("rl_idle2_grant", 32'(GRANT), 32'h0);
        tick();
        chk("rl_next_grant", 32'(GRANT), 32'h8);
        PANEL_CARD_IN = 4'b0000;
        tick();
        tick();
        tick();

        // reload wins over a simultaneous card request in idle
        RELOAD_REQ    = 1'b1;
        PANEL_CARD_IN = 4'b0001;
        tick();
        RELOAD_REQ = 1'b0;
        chk("mx_reload", 32'(CORE_RELOAD), 32'h1);
        chk("mx_grant0", 32'(GRANT), 32'h0);
        tick();
        chk("mx_rel1_reload", 32'(CORE_RELOAD), 32'h0);
        chk("mx_rel1_grant",  32'(GRANT), 32'h0);
        tick();
        tick();
        chk("mx_idle_grant", 32'(GRANT), 32'h0);
        tick();
        chk("mx_grant", 32'(GRANT), 32'h1);

        // reset mid-session
        PANEL_ITEM_CODE = 16'h0007;
        PANEL_KEY_PRESS = 4'b0001;
        #1;
        chk("rs_item_pre", 32'(CORE_ITEM_CODE), 32'h7);
        RESET = 1'b1;
        tick();
        chk("rs_grant", 32'(GRANT), 32'h0);
        chk("rs_item",  32'(CORE_ITEM_CODE), 32'h0);
        chk("rs_busy",  32'(BUSY), 32'h0);
        chk("rs_card",  32'(CORE_CARD_IN), 32'h0);
        RESET           = 1'b0;
        PANEL_KEY_PRESS = 4'b0000;
        PANEL_CARD_IN   = 4'b0011;
        tick();
        chk("rs_ptr_grant", 32'(GRANT), 32'h1);

        // invalid selection ends the session, then panel 1 follows
        CORE_INVALID_SEL = 1'b1;
        tick();
        CORE_INVALID_SEL = 1'b0;
        chk("inv_grant", 32'(GRANT), 32'h0);
        chk("inv_busy",  32'(BUSY), 32'h1);
        tick();
        tick();
        tick();
        chk("inv_next_grant", 32'(GRANT), 32'h2);

        // two end conditions together give one release
        CORE_INVALID_SEL = 1'b1;
        CORE_FAILED_TRAN = 1'b1;
        tick();
        CORE_INVALID_SEL = 1'b0;
        CORE_FAILED_TRAN = 1'b0;
        chk("dual_grant", 32'(GRANT), 32'h0);
        chk("dual_tmo",   32'(TIMEOUT), 32'h0);
        tick();
        chk("dual_rel2_busy", 32'(BUSY), 32'h1);
        tick();
        chk("dual_idle_busy", 32'(BUSY), 32'h0);
        tick();
        chk("dual_stay_grant", 32'(GRANT), 32'h0);
        chk("dual_stay_busy",  32'(BUSY), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_session_arbiter.md
Name: vend_session_arbiter

Overview:
- Shares the single vending-machine core between NUM_PANELS front panels, each with its own card slot and keypad.
- Grants exclusive sessions round-robin and muxes the owner's CARD_IN, KEY_PRESS and ITEM_CODE into the core.
- Detects session end from the core outputs and enforces a session timeout.
- Sequences maintenance reload between sessions.

Parameters:
NUM_PANELS, 4, number of requesting panels (2..8)
SESSION_MAX, 32, maximum session length in cycles before forced release
GUARD_CYCLES, 2, cycles CORE_CARD_IN is held low after a session so the core returns to idle

Ports:
CLK  in  1  clock
RESET  in  1  reset
PANEL_CARD_IN  in  NUM_PANELS  card present per panel (level)
PANEL_KEY_PRESS  in  NUM_PANELS  key strobe per panel
PANEL_ITEM_CODE  in  4*NUM_PANELS  item digit per panel; panel i uses bits [4i+3:4i]
RELOAD_REQ  in  1  maintenance reload request (pulse or level)
CORE_VEND  in  1  core VEND output
CORE_INVALID_SEL  in  1  core INVALID_SEL output
CORE_FAILED_TRAN  in  1  core FAILED_TRAN output
GRANT  out  NUM_PANELS  one-hot session owner, zero when no owner
CORE_CARD_IN  out  1  card level to core
CORE_KEY_PRESS  out  1  owner's key strobe to core
CORE_ITEM_CODE  out  4  owner's item digit to core
CORE_RELOAD  out  1  reload strobe to core
BUSY  out  1  high in any state other than IDLE
TIMEOUT  out  1  one-cycle pulse on forced release

Behaviour:
- Reset: RESET is synchronous, active-high; clock CLK.
  - Reset values: all outputs 0, state IDLE, rr pointer = NUM_PANELS-1 (first winner is panel 0), served mask 0, reload_pending 0, counters 0.
  - Reset mid-session drops GRANT and CORE_CARD_IN on the next edge.
- Eligibility:
  - Panel i is eligible when PANEL_CARD_IN[i]=1 and served[i]=0.
  - served[i] is set when panel i's session ends and cleared whenever PANEL_CARD_IN[i]=0. A card must be removed and reinserted to be served again.
- States: IDLE, SESSION, RELEASE, MAINT.
- IDLE:
  - reload_pending or RELOAD_REQ -> MAINT. Reload wins over simultaneous card requests.
  - Otherwise, if any panel is eligible -> SESSION. The winner is the first eligible index after the pointer, wrapping.
  - GRANT and the pointer are registered on the transition edge. GRANT is visible the cycle SESSION is entered (1-cycle latency from request).
- SESSION:
  - CORE_CARD_IN = PANEL_CARD_IN[owner]; CORE_KEY_PRESS and CORE_ITEM_CODE are combinationally muxed from the owner.
  - Non-owner inputs are ignored.
  - Session cycle counter increments every cycle.
  - Exit to RELEASE on the first of:
    - owner card dropped;
    - CORE_INVALID_SEL=1;
    - CORE_FAILED_TRAN=1;
    - falling edge of CORE_VEND (registered previous value);
    - counter = SESSION_MAX-1. This case also asserts TIMEOUT for that one cycle.
  - On the exit edge: served[owner] is set and GRANT is cleared.
- RELEASE:
  - CORE_CARD_IN=0, CORE_KEY_PRESS=0, CORE_ITEM_CODE=0 for exactly GUARD_CYCLES cycles, then -> IDLE.
- MAINT:
  - CORE_RELOAD=1 for exactly one cycle and reload_pending is cleared, then -> RELEASE (guard applies).
- RELOAD_REQ arriving in SESSION/RELEASE/MAINT sets reload_pending. It is serviced on the next IDLE before any grant.
- Simultaneous end conditions in the same cycle produce a single release. TIMEOUT asserts only if the counter condition is true that cycle.
- Counter width is $clog2(SESSION_MAX); it is cleared on entering SESSION and on RELEASE.
- Pointer arithmetic wraps modulo NUM_PANELS. GRANT is never more than one-hot.

Decomposition:
- Package vend_arb_pkg:
  - state enum (IDLE=2'd0, SESSION=2'd1, RELEASE=2'd2, MAINT=2'd3);
  - ITEM_CODE_W=4 constant.
- Sub-module rr_picker:
  - combinational; inputs eligible mask and pointer;
  - outputs one-hot winner and valid;
  - parameterised by NUM_PANELS.

Test Plan:
- Reset, then PANEL_CARD_IN=4'b1010 -> next cycle GRANT=4'b0010, CORE_CARD_IN=1. After owner card drop: 2 cycles CORE_CARD_IN=0, then GRANT=4'b1000.
- Panel 0 session, CORE_VEND high 1 cycle then low -> release the cycle after the falling edge. Panel 0 card held -> not regranted. After card drop and reinsertion -> regranted.
- Owner holds card with no core response -> TIMEOUT pulse at session cycle 31, GRANT=0 on the next cycle.
- RELOAD_REQ pulse mid-session -> CORE_RELOAD stays 0 until the session ends and the guard passes. Then one CORE_RELOAD cycle precedes the next GRANT.
- RELOAD_REQ and PANEL_CARD_IN=4'b0001 together in IDLE -> MAINT first, GRANT=4'b0001 after the guard.
- RESET asserted mid-session with PANEL_ITEM_CODE=4'h7 on the owner -> next cycle GRANT=0, CORE_ITEM_CODE=0, BUSY=0, pointer restarts so panel 0 wins first.
